uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Sequences the UART receiver. Catches each completed byte (LSR[0]) and pushes it into the RX FIFO,
//  then pulses clear_flags back to the receiver. Folds receiver errors, FIFO drops and a character
//  timeout into sticky status, and drives one level interrupt to the host register block.
// PARAMETERS
//  LVL_W          5    width of fifo_level and rx_thresh (FIFO depth 16 -> 0..16)
//  TIMEOUT_TICKS  768  b_ticks idle with FIFO non-empty before timeout (4 chars x 12 bits x 16)
//  TO_W           10   timeout counter width; must hold TIMEOUT_TICKS
//  DROP_W         8    dropped-byte counter width
// PORTS
//  clock          in   1      system clock
//  reset          in   1      asynchronous, active-high reset
//  b_tick         in   1      16x-oversample baud tick, same as the receiver's
//  rx_lsr         in   8      receiver LSR: [0] done, [1] overrun, [2] parity err, [3] framing err
//  rx_data        in   8      receiver data_out, valid while rx_lsr[0]=1
//  rx_clear_flags out  1      one-cycle pulse to the receiver clear_flags input
//  fifo_full      in   1      RX FIFO full
//  fifo_empty     in   1      RX FIFO empty
//  fifo_level     in   LVL_W  RX FIFO occupancy
//  fifo_rd        in   1      host pop strobe, observed only for the timeout restart
//  fifo_wr        out  1      RX FIFO push strobe
//  fifo_wdata     out  8      RX FIFO push data
//  stat_rd        in   1      host read of stat; clears sticky bits and drop_count
//  ier            in   3      irq enables: [0] level, [1] error, [2] timeout
//  rx_thresh      in   LVL_W  level-irq threshold (1..16)
//  stat           out  8      [0] !fifo_empty, [1] overrun*, [2] parity*, [3] framing*, [4] timeout*,
//                             [5] fifo_full, [7:6] 0 (* = sticky)
//  drop_count     out  DROP_W saturating count of bytes lost to a full FIFO
//  irq            out  1      registered interrupt
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, sticky bits 0, counters 0. The reset takes effect mid-byte with
//   no partial push or pulse. stat[0] and stat[5] track the inputs once reset is released.
//  FSM: IDLE -> CAPT -> PUSH -> CLR -> WAIT -> IDLE.
//   IDLE: when rx_lsr[0]=1, go to CAPT.
//   CAPT: latch rx_data into fifo_wdata and latch rx_lsr[3:1]. Always go to PUSH.
//   PUSH: for one cycle, fifo_wr = !fifo_full.
//    If fifo_full: no write; set overrun*; drop_count += 1, saturating at all-ones.
//    Always go to CLR.
//   CLR: rx_clear_flags = 1 for one cycle. Go to WAIT.
//   WAIT: stay until rx_lsr[0]=0, then go to IDLE. This prevents a double push of one byte.
//  Latency: rx_lsr[0] is first high in cycle 0 -> fifo_wr in cycle 2 -> rx_clear_flags in cycle 3.
//  Error capture: latched rx_lsr[1] ORs into overrun*, [2] into parity*, [3] into framing*.
//   The errored byte is still pushed.
//  stat_rd: clears sticky bits [4:1] and drop_count on the next edge.
//   A set event in the same cycle wins: the bit ends at 1, and drop_count ends at 1.
//  Timeout: the counter increments on b_tick while fifo_empty=0 and the FSM is in IDLE.
//   It is cleared to 0 on fifo_wr, fifo_rd or fifo_empty=1.
//   Reaching TIMEOUT_TICKS sets timeout* and holds the count (no wrap) until cleared.
//  irq (registered, one-cycle lag):
//   (ier[0] & fifo_level >= rx_thresh) | (ier[1] & |stat[3:1]) | (ier[2] & stat[4]).
//  fifo_level compare is unsigned and LVL_W wide. rx_thresh = 0 makes the level term permanently true.
//  b_tick is ignored by the FSM; only the timeout counter uses it.
// STRUCTURE
//  uart_pkg: FSM state localparams (3-bit), LSR bit indices, stat bit indices, default TIMEOUT_TICKS.
//  One sub-module, uart_rx_timeout: tick counter with clear/hold and a timeout pulse output.
//  FSM, sticky status, drop counter and irq stay in uart_rx_ctrl.
// TESTING
//  1. rx_lsr=8'h01, rx_data=8'hA5, FIFO empty -> fifo_wr=1 and fifo_wdata=A5 in cycle 2;
//     rx_clear_flags=1 in cycle 3; exactly one push.
//  2. rx_lsr=8'h05 (parity) with ier=3'b010 -> byte pushed, stat=8'h05, irq=1;
//     a stat_rd pulse -> stat=8'h01, irq=0.
//  3. fifo_full=1, three bytes received -> no fifo_wr; stat[1]=1; drop_count=3.
//     Then 258 drops -> drop_count saturates at 8'hFF.
//  4. One byte in the FIFO, no further rx, ier=3'b100 -> stat[4] and irq rise after 768 b_ticks.
//     A fifo_rd at tick 700 restarts the count.
//  5. rx_thresh=4, ier=3'b001, four bytes pushed -> irq rises the cycle after fifo_level becomes 4.
//  6. Reset asserted in PUSH -> fifo_wr and rx_clear_flags drop immediately; FSM in IDLE;
//     stat[4:1]=0, drop_count=0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and register bit positions for the UART receive path
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CAPT = 3'd1,
    ST_PUSH = 3'd2,
    ST_CLR  = 3'd3,
    ST_WAIT = 3'd4
  } rx_state_e;

  localparam int LSR_DONE = 0;
  localparam int LSR_OVR  = 1;
  localparam int LSR_PAR  = 2;
  localparam int LSR_FRM  = 3;

  localparam int STAT_NEMPTY = 0;
  localparam int STAT_OVR    = 1;
  localparam int STAT_PAR    = 2;
  localparam int STAT_FRM    = 3;
  localparam int STAT_TO     = 4;
  localparam int STAT_FULL   = 5;

  localparam int TIMEOUT_TICKS_DEF = 768;

endpackage

// File: rtl/uart_rx_timeout.sv
// rtl/uart_rx_timeout.sv - character-timeout tick counter with clear, hold at limit and pulse
module uart_rx_timeout #(
  parameter int TIMEOUT_TICKS = 768,
  parameter int TO_W          = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic enable,
  input  logic clear,
  output logic timeout_pulse
);

  localparam logic [TO_W-1:0] LIMIT    = TO_W'(TIMEOUT_TICKS);
  localparam logic [TO_W-1:0] LIMIT_M1 = TO_W'(TIMEOUT_TICKS - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // The count parks at LIMIT so the pulse fires once per idle period.
  always_comb begin
    cnt_d         = cnt_q;
    timeout_pulse = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && enable && (cnt_q != LIMIT)) begin
      cnt_d         = cnt_q + TO_W'(1);
      timeout_pulse = (cnt_q == LIMIT_M1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - moves received bytes into the RX FIFO and folds errors, drops
// and character timeout into sticky status and a level interrupt
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int LVL_W         = 5,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int TO_W          = 10,
  parameter int DROP_W        = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              b_tick,
  input  logic [7:0]        rx_lsr,
  input  logic [7:0]        rx_data,
  output logic              rx_clear_flags,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [LVL_W-1:0]  fifo_level,
  input  logic              fifo_rd,
  output logic              fifo_wr,
  output logic [7:0]        fifo_wdata,
  input  logic              stat_rd,
  input  logic [2:0]        ier,
  input  logic [LVL_W-1:0]  rx_thresh,
  output logic [7:0]        stat,
  output logic [DROP_W-1:0] drop_count,
  output logic              irq
);

  rx_state_e         state_q, state_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [2:0]        err_q, err_d;
  logic [3:0]        sticky_q, sticky_d;   // {timeout, framing, parity, overrun}
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              irq_q, irq_d;
  logic              push_drop;
  logic              in_push;
  logic              to_pulse;
  logic [3:0]        sticky_set;

  always_comb begin
    state_d        = state_q;
    wdata_d        = wdata_q;
    err_d          = err_q;
    fifo_wr        = 1'b0;
    rx_clear_flags = 1'b0;
    push_drop      = 1'b0;
    in_push        = 1'b0;
    case (state_q)
      ST_IDLE: if (rx_lsr[LSR_DONE]) state_d = ST_CAPT;
      ST_CAPT: begin
        wdata_d = rx_data;
        err_d   = rx_lsr[LSR_FRM:LSR_OVR];
        state_d = ST_PUSH;
      end
      ST_PUSH: begin
        in_push   = 1'b1;
        fifo_wr   = !fifo_full;
        push_drop = fifo_full;
        state_d   = ST_CLR;
      end
      ST_CLR: begin
        rx_clear_flags = 1'b1;
        state_d        = ST_WAIT;
      end
      // Holding here until done falls keeps one byte from being pushed twice.
      ST_WAIT: if (!rx_lsr[LSR_DONE]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  uart_rx_timeout #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .TO_W         (TO_W)
  ) u_timeout (
    .clock        (clock),
    .reset        (reset),
    .tick         (b_tick),
    .enable       ((state_q == ST_IDLE) && !fifo_empty),
    .clear        (fifo_wr || fifo_rd || fifo_empty),
    .timeout_pulse(to_pulse)
  );

  // Set events are ORed after the read-clear so a same-cycle event survives.
  always_comb begin
    sticky_set = {to_pulse,
                  in_push & err_q[2],
                  in_push & err_q[1],
                  in_push & (err_q[0] | fifo_full)};
    sticky_d   = (stat_rd ? 4'b0000 : sticky_q) | sticky_set;

    drop_d = drop_q;
    if (stat_rd)                         drop_d = push_drop ? DROP_W'(1) : '0;
    else if (push_drop && drop_q != '1)  drop_d = drop_q + DROP_W'(1);

    irq_d = (ier[0] && (fifo_level >= rx_thresh)) ||
            (ier[1] && (|sticky_q[2:0])) ||
            (ier[2] && sticky_q[3]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wdata_q  <= '0;
      err_q    <= '0;
      sticky_q <= '0;
      drop_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      drop_q   <= drop_d;
      irq_q    <= irq_d;
    end
  end

  assign fifo_wdata = wdata_q;
  assign drop_count = drop_q;
  assign irq        = irq_q;
  assign stat       = {2'b00, fifo_full, sticky_q, !fifo_empty};

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl against a behavioural model
module tb_uart_rx_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       b_tick;
  logic [7:0] rx_lsr;
  logic [7:0] rx_data;
  logic       rx_clear_flags;
  logic       fifo_full;
  logic       fifo_empty;
  logic [4:0] fifo_level;
  logic       fifo_rd;
  logic       fifo_wr;
  logic [7:0] fifo_wdata;
  logic       stat_rd;
  logic [2:0] ier;
  logic [4:0] rx_thresh;
  logic [7:0] stat;
  logic [7:0] drop_count;
  logic       irq;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: FIFO occupancy, sticky {to, fr, par, ov}, drop tally
  int       m_level;
  logic [3:0] m_stk;
  int       m_drops;
  logic     irq_c3, irq_c4;

  uart_rx_ctrl dut (
    .clock(clock), .reset(reset), .b_tick(b_tick), .rx_lsr(rx_lsr), .rx_data(rx_data),
    .rx_clear_flags(rx_clear_flags), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_level(fifo_level), .fifo_rd(fifo_rd), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
    .stat_rd(stat_rd), .ier(ier), .rx_thresh(rx_thresh), .stat(stat),
    .drop_count(drop_count), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_level(input int n);
    m_level    = n;
    fifo_level = 5'(n);
    fifo_empty = (n == 0);
    fifo_full  = (n == 16);
  endtask

  function automatic logic [7:0] exp_stat();
    return {2'b00, m_level == 16, m_stk, m_level != 0};
  endfunction

  task automatic clear_stat();
    stat_rd = 1'b1;
    step();
    stat_rd = 1'b0;
    m_stk   = 4'b0;
    m_drops = 0;
  endtask

  // Plays one received character; cycle 0 is the first cycle with done=1.
  task automatic send_byte(input logic [7:0] d, input logic [2:0] err, input logic rd_in_push);
    logic exp_wr;
    int   n_wr;
    exp_wr  = (m_level != 16);
    n_wr    = 0;
    rx_data = d;
    rx_lsr  = {4'b0, err, 1'b1};
    for (int c = 0; c < 8; c++) begin
      if (c == 2) stat_rd = rd_in_push;
      if (c == 6) rx_lsr = 8'h00;
      n_wr += int'(fifo_wr);
      if (c == 2) begin
        n_cmp++;
        if (fifo_wr !== exp_wr) begin
          n_bad++; $display("FAIL push_strobe: got %b expected %b", fifo_wr, exp_wr);
        end
        if (exp_wr) begin
          n_cmp++;
          if (fifo_wdata !== d) begin
            n_bad++; $display("FAIL push_data: got %h expected %h", fifo_wdata, d);
          end
        end
      end
      n_cmp++;
      if (rx_clear_flags !== (c == 3)) begin
        n_bad++; $display("FAIL clear_pulse c%0d: got %b expected %b", c, rx_clear_flags, c == 3);
      end
      if (c == 3) irq_c3 = irq;
      if (c == 4) irq_c4 = irq;
      step();
      if (c == 2) begin
        stat_rd = 1'b0;
        if (rd_in_push) begin
          m_stk   = 4'b0;
          m_drops = 0;
        end
        m_stk[0] |= err[0] | !exp_wr;
        m_stk[1] |= err[1];
        m_stk[2] |= err[2];
        if (!exp_wr) m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
        if (exp_wr) set_level(m_level + 1);
      end
    end
    n_cmp++;
    if (n_wr !== int'(exp_wr)) begin
      n_bad++; $display("FAIL push_count: got %0d expected %0d", n_wr, int'(exp_wr));
    end
    n_cmp++;
    if (stat !== exp_stat()) begin
      n_bad++; $display("FAIL stat_after_byte: got %h expected %h", stat, exp_stat());
    end
    n_cmp++;
    if (drop_count !== 8'(m_drops)) begin
      n_bad++; $display("FAIL drop_count: got %0d expected %0d", drop_count, m_drops);
    end
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      b_tick = 1'b1;
      step();
      b_tick = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; b_tick = 0; rx_lsr = 0; rx_data = 0; fifo_rd = 0; stat_rd = 0;
    ier = 3'b000; rx_thresh = 5'd1; set_level(0);
    m_stk = 0; m_drops = 0;
    step(); step();
    n_cmp++;
    if ({fifo_wr, rx_clear_flags, irq, fifo_wdata, stat, drop_count} !== 27'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected 0",
                        {fifo_wr, rx_clear_flags, irq, fifo_wdata, stat, drop_count});
    end
    @(negedge clock) reset = 1'b0;
    step();
  endtask

  task automatic test_single_byte();
    send_byte(8'hA5, 3'b000, 1'b0);
  endtask

  task automatic test_parity_irq();
    ier = 3'b010;
    send_byte(8'h3C, 3'b010, 1'b0);
    n_cmp++;
    if (stat !== 8'h05) begin
      n_bad++; $display("FAIL parity_stat: got %h expected 05", stat);
    end
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++; $display("FAIL parity_irq: got %b expected 1", irq);
    end
    clear_stat();
    n_cmp++;
    if (stat !== 8'h01) begin
      n_bad++; $display("FAIL stat_rd_clear: got %h expected 01", stat);
    end
    step();
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++; $display("FAIL irq_after_rd: got %b expected 0", irq);
    end
    ier = 3'b000;
  endtask

  task automatic test_drops();
    set_level(16);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 3'b000, 1'b0);
    n_cmp++;
    if (drop_count !== 8'd3 || stat[1] !== 1'b1) begin
      n_bad++; $display("FAIL three_drops: got cnt=%0d ov=%b expected cnt=3 ov=1", drop_count, stat[1]);
    end
    for (int i = 0; i < 258; i++) send_byte(8'($urandom), 3'b000, 1'b0);
    n_cmp++;
    if (drop_count !== 8'hFF) begin
      n_bad++; $display("FAIL drop_saturate: got %h expected ff", drop_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      set_level(($urandom_range(0, 2) == 0) ? 16 : int'($urandom_range(0, 15)));
      send_byte(8'($urandom), 3'($urandom), $urandom_range(0, 3) == 0);
    end
    clear_stat();
    n_cmp++;
    if (stat[4:1] !== 4'b0 || drop_count !== 8'd0) begin
      n_bad++; $display("FAIL random_clear: got stk=%b cnt=%0d expected 0", stat[4:1], drop_count);
    end
  endtask

  task automatic test_level_irq();
    set_level(0);
    rx_thresh = 5'd4;
    ier = 3'b001;
    step(); step();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 3'b000, 1'b0);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++; $display("FAIL level_below: got %b expected 0", irq);
    end
    send_byte(8'($urandom), 3'b000, 1'b0);
    n_cmp++;
    if (irq_c3 !== 1'b0 || irq_c4 !== 1'b1) begin
      n_bad++; $display("FAIL level_edge: got c3=%b c4=%b expected c3=0 c4=1", irq_c3, irq_c4);
    end
    set_level(0);
    rx_thresh = 5'd0;
    step(); step();
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++; $display("FAIL thresh_zero: got %b expected 1", irq);
    end
    ier = 3'b000;
    rx_thresh = 5'd1;
    step(); step();
  endtask

  task automatic test_timeout();
    set_level(1);
    clear_stat();
    ier = 3'b100;
    fifo_rd = 1'b1; step(); fifo_rd = 1'b0;
    do_ticks(767);
    n_cmp++;
    if (stat[4] !== 1'b0 || irq !== 1'b0) begin
      n_bad++; $display("FAIL timeout_early: got to=%b irq=%b expected 0 0", stat[4], irq);
    end
    do_ticks(1);
    n_cmp++;
    if (stat[4] !== 1'b1 || irq !== 1'b1) begin
      n_bad++; $display("FAIL timeout_fire: got to=%b irq=%b expected 1 1", stat[4], irq);
    end
    clear_stat();
    step();
    do_ticks(700);
    fifo_rd = 1'b1; step(); fifo_rd = 1'b0;
    do_ticks(767);
    n_cmp++;
    if (stat[4] !== 1'b0) begin
      n_bad++; $display("FAIL timeout_restart: got %b expected 0", stat[4]);
    end
    do_ticks(1);
    n_cmp++;
    if (stat[4] !== 1'b1 || irq !== 1'b1) begin
      n_bad++; $display("FAIL timeout_refire: got to=%b irq=%b expected 1 1", stat[4], irq);
    end
    m_stk[3] = 1'b1;
    ier = 3'b000;
    clear_stat();
  endtask

  task automatic test_reset_in_push();
    set_level(16);
    send_byte(8'h11, 3'b100, 1'b0);
    set_level(5);
    rx_data = 8'h77;
    rx_lsr  = 8'h01;
    step(); step();
    n_cmp++;
    if (fifo_wr !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_push: got %b expected 1", fifo_wr);
    end
    reset = 1'b1;
    #1;
    m_stk = 0; m_drops = 0;
    n_cmp++;
    if ({fifo_wr, rx_clear_flags} !== 2'b00 || stat[4:1] !== 4'b0 || drop_count !== 8'd0) begin
      n_bad++; $display("FAIL reset_in_push: got wr=%b clr=%b stk=%b cnt=%0d expected all 0",
                        fifo_wr, rx_clear_flags, stat[4:1], drop_count);
    end
    rx_lsr = 8'h00;
    @(negedge clock) reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if ({fifo_wr, rx_clear_flags} !== 2'b00) begin
        n_bad++; $display("FAIL post_reset_quiet: got wr=%b clr=%b expected 0 0", fifo_wr, rx_clear_flags);
      end
    end
    send_byte(8'h5A, 3'b000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_parity_irq();
    test_drops();
    test_random();
    test_level_irq();
    test_timeout();
    test_reset_in_push();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
